// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Baud select changes are deferred to IDLE; a watchdog aborts a frame whose tx_done never arrives.
module uart_tx_scheduler #(
    parameter int             NREQ           = 4,
    parameter int             TIMEOUT_CYCLES = 200000,
    parameter logic [2:0]     SEL_RESET      = 3'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     ack,
    input  logic [2:0]          sel_in,
    input  logic                sel_wr,
    output logic [2:0]          sel_out,
    output logic [7:0]          tx_data_out,
    output logic                tx_start,
    input  logic                tx_done,
    output logic [2:0]          grant_id,
    output logic                busy,
    output logic                err_timeout,
    input  logic                err_clr
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        sel_out_q, sel_out_d;
    logic [2:0]        sel_pend_val_q, sel_pend_val_d;
    logic              sel_pending_q, sel_pending_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [2:0]        grant_id_q, grant_id_d;
    logic              tx_start_q, tx_start_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Requests and data widened to eight lanes so a 3-bit index is always legal.
    logic [7:0]        req_ext;
    logic [63:0]       data_ext;
    logic              pick_found;
    logic [2:0]        pick_idx;
    logic [3:0]        rr_sum;
    logic [2:0]        rr_cand;
    logic [NREQ-1:0]   ack_sel;

    assign req_ext  = 8'(req);
    assign data_ext = 64'(req_data);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        rr_cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_sum  = {1'b0, last_q} + 4'(k);
            rr_cand = 3'(rr_sum >= 4'(NREQ) ? rr_sum - 4'(NREQ) : rr_sum);
            if (!pick_found && req_ext[rr_cand]) begin
                pick_found = 1'b1;
                pick_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        ack_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack_sel[i] = (grant_id_q == 3'(i));
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        sel_out_d      = sel_out_q;
        sel_pend_val_d = sel_wr ? sel_in : sel_pend_val_q;
        sel_pending_d  = sel_pending_q | sel_wr;
        tx_data_d      = tx_data_q;
        grant_id_d     = grant_id_q;
        tx_start_d     = 1'b0;
        ack_d          = '0;
        err_d          = err_q & ~err_clr;
        cnt_d          = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (sel_pending_q) begin
                    sel_out_d     = sel_pend_val_q;
                    sel_pending_d = sel_wr;
                end else if (pick_found) begin
                    tx_data_d  = data_ext[{pick_idx, 3'b000} +: 8];
                    grant_id_d = pick_idx;
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (tx_done) begin
                    ack_d   = ack_sel;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    ack_d   = ack_sel;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                last_d  = grant_id_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            last_q         <= 3'(NREQ - 1);
            sel_out_q      <= SEL_RESET;
            sel_pend_val_q <= '0;
            sel_pending_q  <= 1'b0;
            tx_data_q      <= '0;
            grant_id_q     <= '0;
            tx_start_q     <= 1'b0;
            ack_q          <= '0;
            err_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            sel_out_q      <= sel_out_d;
            sel_pend_val_q <= sel_pend_val_d;
            sel_pending_q  <= sel_pending_d;
            tx_data_q      <= tx_data_d;
            grant_id_q     <= grant_id_d;
            tx_start_q     <= tx_start_d;
            ack_q          <= ack_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign ack         = ack_q;
    assign sel_out     = sel_out_q;
    assign tx_data_out = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: NREQ=4, watchdog shortened to 100 cycles,
// tx_done driven by hand in place of uart_top.
module tb_uart_tx_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  req_data;
    logic [3:0]   ack;
    logic [2:0]   sel_in;
    logic         sel_wr;
    logic [2:0]   sel_out;
    logic [7:0]   tx_data_out;
    logic         tx_start;
    logic         tx_done;
    logic [2:0]   grant_id;
    logic         busy;
    logic         err_timeout;
    logic         err_clr;

    int errors = 0;
    int checks = 0;

    uart_tx_scheduler #(
        .NREQ           (4),
        .TIMEOUT_CYCLES (100),
        .SEL_RESET      (3'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .sel_in      (sel_in),
        .sel_wr      (sel_wr),
        .sel_out     (sel_out),
        .tx_data_out (tx_data_out),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_frame(input int id, input logic [7:0] data, input int wait_cyc,
                             input logic [3:0] req_after);
        bit ok;
        wait_start(ok);
        chk("start_seen", 64'(ok), 64'd1);
        chk("grant_id", 64'(grant_id), 64'(id));
        chk("tx_data", 64'(tx_data_out), 64'(data));
        tick();
        chk("start_pulse_len", 64'(tx_start), 64'd0);
        repeat (wait_cyc) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("ack", 64'(ack), 64'd1 << id);
        req = req_after;
        tick();
        chk("ack_clear", 64'(ack), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        sel_in   = '0;
        sel_wr   = 1'b0;
        tx_done  = 1'b0;
        err_clr  = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_start", 64'(tx_start), 64'd0);
        chk("rst_sel", 64'(sel_out), 64'd0);
        chk("rst_data", 64'(tx_data_out), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        rst = 1'b0;
        tick();

        // Single requester: start one cycle after req, ack one cycle after tx_done.
        req           = 4'b0001;
        req_data[7:0] = 8'hA5;
        tick();
        chk("single_start", 64'(tx_start), 64'd1);
        chk("single_data", 64'(tx_data_out), 64'hA5);
        chk("single_gid", 64'(grant_id), 64'd0);
        chk("single_busy", 64'(busy), 64'd1);
        tick();
        chk("single_start_off", 64'(tx_start), 64'd0);
        tick();
        chk("single_no_early_ack", 64'(ack), 64'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("single_ack", 64'(ack), 64'b0001);
        chk("single_busy_rel", 64'(busy), 64'd1);
        req = 4'b0000;
        tick();
        chk("single_ack_off", 64'(ack), 64'd0);
        chk("single_idle", 64'(busy), 64'd0);
        chk("single_hold", 64'(tx_data_out), 64'hA5);

        // Fairness: last grant was 0, so rotation continues 1,2,3,0.
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req      = 4'b1111;
        run_frame(1, 8'h11, 2, 4'b1111);
        run_frame(2, 8'h12, 0, 4'b1111);
        run_frame(3, 8'h13, 3, 4'b1111);
        run_frame(0, 8'h10, 1, 4'b0000);

        // Baud change during WAIT, then a second write in the application cycle.
        req = 4'b0100;
        tick();
        chk("baud_gid", 64'(grant_id), 64'd2);
        tick();
        sel_in = 3'd2;
        sel_wr = 1'b1;
        tick();
        sel_wr = 1'b0;
        chk("baud_hold_wait", 64'(sel_out), 64'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("baud_ack", 64'(ack), 64'b0100);
        chk("baud_hold_rel", 64'(sel_out), 64'd0);
        req = 4'b0010;
        tick();
        chk("baud_hold_idle", 64'(sel_out), 64'd0);
        chk("baud_idle_busy", 64'(busy), 64'd0);
        sel_in = 3'd5;
        sel_wr = 1'b1;
        tick();
        sel_wr = 1'b0;
        chk("baud_applied", 64'(sel_out), 64'd2);
        chk("baud_no_grant1", 64'(tx_start), 64'd0);
        tick();
        chk("baud_second", 64'(sel_out), 64'd5);
        chk("baud_no_grant2", 64'(tx_start), 64'd0);
        tick();
        chk("baud_late_start", 64'(tx_start), 64'd1);
        chk("baud_late_gid", 64'(grant_id), 64'd1);
        chk("baud_late_data", 64'(tx_data_out), 64'h11);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("baud_late_ack", 64'(ack), 64'b0010);
        req = 4'b0000;
        tick();

        // Watchdog: tx_done never arrives, ack lands at START+101.
        req = 4'b0010;
        tick();
        chk("wd_start", 64'(tx_start), 64'd1);
        chk("wd_gid", 64'(grant_id), 64'd1);
        repeat (99) tick();
        tick();
        chk("wd_no_ack_100", 64'(ack), 64'd0);
        chk("wd_no_err_100", 64'(err_timeout), 64'd0);
        chk("wd_busy_100", 64'(busy), 64'd1);
        tick();
        chk("wd_ack_101", 64'(ack), 64'b0010);
        chk("wd_err_101", 64'(err_timeout), 64'd1);
        req = 4'b0000;
        tick();
        chk("wd_err_sticky", 64'(err_timeout), 64'd1);
        chk("wd_idle", 64'(busy), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_err_clr", 64'(err_timeout), 64'd0);

        // tx_done coincident with the timeout cycle wins: no error.
        req = 4'b0010;
        tick();
        chk("race_start", 64'(tx_start), 64'd1);
        repeat (99) tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("race_ack", 64'(ack), 64'b0010);
        chk("race_no_err", 64'(err_timeout), 64'd0);
        req = 4'b0000;
        tick();

        // tx_done outside WAIT is ignored.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_done_busy", 64'(busy), 64'd0);
        chk("stray_done_ack", 64'(ack), 64'd0);

        // Reset mid-frame: outputs clear at once, no ack, requester 0 first after release.
        req = 4'b1000;
        tick();
        chk("rstmf_gid", 64'(grant_id), 64'd3);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rstmf_busy", 64'(busy), 64'd0);
        chk("rstmf_ack", 64'(ack), 64'd0);
        chk("rstmf_data", 64'(tx_data_out), 64'd0);
        chk("rstmf_gid0", 64'(grant_id), 64'd0);
        chk("rstmf_sel", 64'(sel_out), 64'd0);
        tick();
        chk("rstmf_no_ack", 64'(ack), 64'd0);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        chk("rstmf_first_start", 64'(tx_start), 64'd1);
        chk("rstmf_first_gid", 64'(grant_id), 64'd0);
        chk("rstmf_first_data", 64'(tx_data_out), 64'h10);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("rstmf_ack0", 64'(ack), 64'b0001);
        req = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter of `uart_top` among up to eight byte-producing requesters. It owns `uart_top.tx_data_in`, `tx_start` and `sel`, and consumes `tx_done`. Baud-rate changes are applied only between frames, and a watchdog recovers from a transmitter that never signals completion. It sits between the client logic and `uart_top` and shares `clk` and `rst` with it.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `TIMEOUT_CYCLES`, 200000: number of WAIT cycles without `tx_done` before abort. Must exceed 11 × (sysclk / low_baudrate); 114,587 for 50 MHz / 4800.
- `SEL_RESET`, 3'd0: reset value of `sel_out`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in NREQ: per-requester byte-pending request.
- `req_data` in 8×NREQ: byte of requester i at bits [8i+7:8i].
- `ack` out NREQ: one-cycle pulse per requester; byte consumed (sent or aborted).
- `sel_in` in 3: new baud select value.
- `sel_wr` in 1: write strobe for `sel_in`.
- `sel_out` out 3: connects to `uart_top.sel`.
- `tx_data_out` out 8: connects to `uart_top.tx_data_in`.
- `tx_start` out 1: connects to `uart_top.tx_start`.
- `tx_done` in 1: from `uart_top.tx_done`.
- `grant_id` out 3: index of the current or last granted requester.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err_timeout` out 1: sticky watchdog error flag.
- `err_clr` in 1: clears `err_timeout`.

## Operation
- **FSM states:** IDLE, START, WAIT, RELEASE. Encoding is free; `busy = (state != IDLE)`, decoded directly from state.
- **Requester contract:** raise `req` with `req_data` stable, and hold both until `ack`. On `ack`, either deassert `req` at the following edge or present the next byte.
- **IDLE, highest priority:** if `sel_pending`, load `sel_out <= sel_pend_val`, clear `sel_pending`, and stay in IDLE. No grant is made that cycle.
- **IDLE, otherwise:** if any `req` is high, pick the first set bit scanning `last+1, last+2, …` modulo NREQ. Load `tx_data_out <=` that requester's byte and `grant_id <=` its index, then go to START.
- **START:** `tx_start = 1` for exactly this one cycle; then go to WAIT. Clear the watchdog counter on entry.
- **WAIT:** the counter increments every cycle.
  - On `tx_done`: go to RELEASE.
  - Else, when the counter reaches `TIMEOUT_CYCLES - 1`: set `err_timeout` and go to RELEASE.
  - `tx_done` wins over a simultaneous timeout.
- **RELEASE:** `ack[grant_id] = 1` for this one cycle, set `last <= grant_id`, then go to IDLE. The byte is dropped on timeout; there is no retry.
- **Hold rule:** `tx_data_out` holds its value from grant until the next grant.
- **`sel_wr` capture:** captures `sel_in` into `sel_pend_val` and sets `sel_pending` in any state.
  - Multiple writes before application: the last one wins.
  - `sel_wr` in the same cycle as application: the new value is captured and `sel_pending` stays set.
  - `sel_out` never changes outside IDLE.
- **`err_clr`:** clears `err_timeout`. A set in the same cycle wins.
- **`tx_done` outside WAIT:** ignored.
- **Width rules:** the watchdog counter is `$clog2(TIMEOUT_CYCLES+1)` bits. `last` is 3 bits and is compared modulo NREQ. Unused `grant_id` bits are 0.

## Timing
- **Reset values:**
  - state = IDLE, `last = NREQ-1` (so requester 0 is first), `sel_out = SEL_RESET`, `sel_pending = 0`.
  - `tx_data_out = 0`, `grant_id = 0`, `tx_start = 0`, `ack = 0`, `err_timeout = 0`, `busy = 0`.
- **Reset mid-frame:** all state returns to reset values immediately. The pending byte is dropped with no `ack`. `uart_top` is reset by the same `rst`.
- **Latency:**
  - `req` high in IDLE at cycle t gives `tx_start` high in cycle t+1.
  - `tx_done` at cycle d gives `ack` in cycle d+1 and IDLE in cycle d+2.
  - The next `tx_start` is at d+3 at the earliest.
  - A pending `sel` adds one IDLE cycle.
- **Transmitter safety:** the earliest restart (d+3) is safe because `Tx` is already idle when `tx_done` pulses.
- **Stale-request safety:** the requester sees `ack` in RELEASE, so a stale `req` is never re-sampled.
- **Registered outputs:** `tx_start` and `ack` are registered single-cycle pulses and are never high in consecutive cycles.

## Test plan
- **Single requester:** `req[0] = 1`, `req_data[7:0] = 8'hA5`, `uart_top` connected → `tx_start` one cycle later with `tx_data_out = 8'hA5`; serial frame 0, 10100101 LSB-first, parity 0, 1; `ack[0]` pulses one cycle after `tx_done`.
- **Fairness:** all four `req` held continuously with bytes 8'h10..8'h13 → grant order 0,1,2,3,0,…; exactly one `ack` per frame; no requester is starved.
- **Baud change mid-frame:** `sel_wr` with `sel_in = 3'd2` during WAIT → `sel_out` stays at its old value until the cycle after RELEASE→IDLE; the next frame's bit period is base/4.
- **Watchdog:** `TIMEOUT_CYCLES = 100`, `tx_done` tied low, `req[1] = 1` → `ack[1]` at START+101; `err_timeout = 1` and stays set; `err_clr` clears it.
- **Reset mid-frame:** `rst` pulsed during WAIT → all outputs return to reset values that cycle; no `ack`; after release, requester 0 wins first.
- **Edge cases:**
  - `tx_done` and timeout in the same cycle → no `err_timeout`.
  - `sel_wr` in the application cycle → the second value is applied one IDLE cycle later.
